// File: rtl/led_seq_pkg.sv
// Shared types and the per-mode LED pattern for the run-light sequencer.
// LED values are active-low: a 0 bit lights the LED.
package led_seq_pkg;

    localparam int SPEED_W = 2;
    localparam int POS_W   = 2;

    typedef enum logic [1:0] {
        MODE_RUN_L = 2'd0,
        MODE_RUN_R = 2'd1,
        MODE_PING  = 2'd2,
        MODE_BLINK = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [3:0] LED_ALL_OFF = 4'b1111;
    localparam logic [3:0] LED_ALL_ON  = 4'b0000;

    // LED image shown for a given mode at position pos (active-low).
    function automatic logic [3:0] pattern(input mode_t mode, input logic [POS_W-1:0] pos);
        case (mode)
            MODE_RUN_R: pattern = ~(4'b1000 >> pos);
            MODE_BLINK: pattern = pos[0] ? LED_ALL_OFF : LED_ALL_ON;
            default:    pattern = ~(4'b0001 << pos);
        endcase
    endfunction

    function automatic mode_t next_mode(input mode_t mode);
        next_mode = mode_t'(mode + 2'd1);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: emits a one-cycle tick every (STEP_CNT >> speed) unpaused cycles.
// clear restarts the count so a new mode waits a full period.
module led_tick_gen
    import led_seq_pkg::*;
#(
    parameter int STEP_CNT = 500_000,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic [SPEED_W-1:0] speed,
    input  logic               pause,
    input  logic               clear,
    output logic               tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] period_m1;

    assign period    = CNT_W'(STEP_CNT) >> speed;
    assign period_m1 = period - CNT_W'(1);

    // >= rather than == so a faster speed chosen mid-count wraps at once.
    assign tick = ~pause & (cnt >= period_m1);

    // NOTE: registers are written with non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!pause) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Four-LED run-light sequencer: mode FSM, position/direction tracking and the
// registered active-low LED drive, stepped by led_tick_gen.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int STEP_CNT = 500_000,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               mode_next,
    input  logic               pause,
    input  logic [SPEED_W-1:0] speed,
    output logic [3:0]         led,
    output logic [1:0]         mode,
    output logic               step_tick
);

    mode_t            mode_q, mode_d;
    dir_t             dir_q,  dir_d;
    logic [POS_W-1:0] pos_q,  pos_d;
    logic [3:0]       led_q,  led_d;
    logic             step_q, step_d;
    logic             tick;

    led_tick_gen #(
        .STEP_CNT (STEP_CNT),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk     (clk),
        .n_reset (n_reset),
        .speed   (speed),
        .pause   (pause),
        .clear   (mode_next),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            mode_q <= MODE_RUN_L;
            dir_q  <= DIR_UP;
            pos_q  <= '0;
            led_q  <= LED_ALL_OFF;
            step_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
            pos_q  <= pos_d;
            led_q  <= led_d;
            step_q <= step_d;
        end
    end

    // NOTE: every variable gets its hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        pos_d  = pos_q;
        led_d  = led_q;
        step_d = 1'b0;

        if (mode_next) begin
            // A mode change swallows any coincident tick.
            mode_d = next_mode(mode_q);
            dir_d  = DIR_UP;
            pos_d  = '0;
            led_d  = LED_ALL_OFF;
        end else if (tick) begin
            led_d  = pattern(mode_q, pos_q);
            step_d = 1'b1;
            case (mode_q)
                MODE_PING: begin
                    // Reverse at the ends so each end LED shows once per bounce.
                    if (dir_q == DIR_UP) begin
                        if (pos_q == 2'd3) begin
                            pos_d = 2'd2;
                            dir_d = DIR_DOWN;
                        end else begin
                            pos_d = pos_q + 2'd1;
                        end
                    end else begin
                        if (pos_q == 2'd0) begin
                            pos_d = 2'd1;
                            dir_d = DIR_UP;
                        end else begin
                            pos_d = pos_q - 2'd1;
                        end
                    end
                end
                MODE_BLINK: pos_d = pos_q ^ 2'd1;
                default:    pos_d = pos_q + 2'd1;
            endcase
        end
    end

    assign led       = led_q;
    assign mode      = mode_q;
    assign step_tick = step_q;

endmodule
